reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised multi-read-port register file with an integrated scoreboard.
- Sits between ID and the EX/MEM/WB stages. It serves all ID operand reads combinationally, with bypass from the EX result and the WB write.
- Tracks in-flight destination registers so that long-latency producers (loads, mul/div) stall ID until their result can be bypassed.
- Supports a pipeline flush that clears all pending marks.

Parameters:
- DATA_W, 32, register/word width in bits.
- REG_NUM, 32, number of architectural registers; register 0 is hard-wired to zero.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= REG_NUM.
- READ_PORTS, 2, number of independent ID read ports.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wb_en  input  1  writeback enable.
- wb_addr  input  ADDR_W  writeback destination.
- wb_data  input  DATA_W  writeback value.
- rd_en  input  READ_PORTS  per-port read enable.
- rd_addr  input  READ_PORTS*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  output  READ_PORTS*DATA_W  packed read values; same packing.
- ex_dest  input  ADDR_W  destination of the instruction currently in EX.
- ex_we  input  1  the EX instruction writes a register.
- ex_ready  input  1  EX result is final this cycle (0 for a load or unfinished mul/div).
- ex_result  input  DATA_W  EX result value.
- issue_valid  input  1  the ID instruction issues this cycle if not stalled.
- issue_dest  input  ADDR_W  destination of the issuing instruction.
- issue_we  input  1  the issuing instruction writes a register.
- flush  input  1  synchronous pipeline flush.
- stall  output  1  ID must hold; OR of the per-port stalls.
- pending  output  REG_NUM  scoreboard state, for debug/verification.

Behaviour:
- Reset (rst_n low, asynchronous): all registers become 0 and all pending bits clear. Consequently rd_data reads 0 and stall is 0 immediately.
- Write: on the rising edge, when wb_en is high and wb_addr != 0, registers[wb_addr] <= wb_data. A write to address 0 is ignored.
- Read, per port i, combinational. Priority:
  1. If rd_en[i] is 0, or the address is 0, the port reads 0 and does not stall.
  2. Else if ex_we is high and the address equals ex_dest: if ex_ready is high the port returns ex_result with no stall; if ex_ready is low the port returns 0 and asserts stall.
  3. Else if wb_en is high and the address equals wb_addr: the port returns wb_data.
  4. Else if pending[addr] is set: the port returns 0 and asserts stall.
  5. Else the port returns registers[addr].
- A set pending bit on a register that EX or WB does not currently cover means the producer sits in a stage with no bypass (for example a multi-cycle unit). The port stalls until WB for that register occurs.
- Scoreboard set: on the rising edge, when issue_valid & issue_we & !stall & !flush and issue_dest != 0, set pending[issue_dest].
- Scoreboard clear: on the rising edge, when wb_en is high, clear pending[wb_addr].
- Same-edge set and clear on one register: set wins, because the new producer supersedes the old one.
- Flush: when flush is high, all pending bits clear on the next edge. The set from a same-cycle issue is suppressed. The WB write on that edge still updates the array. Upstream guarantees that flushed instructions never reach WB.
- pending[0] is constantly 0.
- Latency: reads take 0 cycles. A written value is visible through the bypass in the same cycle and through the array from the next cycle.
- All ports are evaluated independently. Two ports with the same address return identical data.

Decomposition:
- Shared package holds DATA_W, REG_NUM, ADDR_W, ZERO_WORD, REG_ZERO, ENABLE and DISABLE.
- One sub-module, rf_read_port, contains the per-port mux and stall logic and is instantiated READ_PORTS times in a generate loop. The scoreboard and the storage array stay in the top module.

Test Plan:
1. Reset mid-operation: write r3=0x1234, then pulse rst_n low asynchronously between edges. rd_data for r3 returns 0 immediately, pending is all-zero and stall=0.
2. WB bypass with the array settling: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF while port0 reads r5. Port0 returns 0xDEADBEEF in that cycle. On the next cycle, with wb_en=0, port0 still returns 0xDEADBEEF from the array.
3. Load-use stall: ex_dest=7, ex_we=1, ex_ready=0 while port1 reads r7. stall=1 and port1 returns 0. On the next cycle, ex_ready=1 with ex_result=0x55 gives stall=0 and port1 returns 0x55.
4. Scoreboard on a multi-cycle op: issue r9 (issue_valid=1, issue_we=1, no stall). pending[9]=1. Read r9 with EX/WB on other registers gives stall=1 for 3 cycles. WB of r9 with 0xA5 gives stall=0 and data 0xA5 in the same cycle, and pending[9]=0 after the edge.
5. Simultaneous set and clear: issue r4 while WB writes r4 on the same edge. pending[4]=1 afterwards and registers[4] holds the WB value.
6. Flush and zero register: pending holds {r2,r6}, then flush=1 together with issue_valid for r8. After the edge pending is all-zero. Issue to r0 and write to r0 leave pending[0]=0, and r0 reads 0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared sizing constants and encodings for the register file with scoreboard.
package reg_file_sb_pkg;
  localparam int DATA_W  = 32;
  localparam int REG_NUM = 32;
  localparam int ADDR_W  = 5;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [ADDR_W-1:0] REG_ZERO  = '0;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
endpackage

// File: rtl/reg_file_sb_rf_read_port.sv
// One ID read port: bypass priority EX over WB over array, with stall on
// unfinished EX results and on pending long-latency producers.
module rf_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              ex_we_i,
  input  logic [ADDR_W-1:0] ex_dest_i,
  input  logic              ex_ready_i,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              pend_i,
  input  logic [DATA_W-1:0] arr_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o
);
  import reg_file_sb_pkg::ENABLE;
  import reg_file_sb_pkg::DISABLE;

  always_comb begin
    data_o  = '0;
    stall_o = DISABLE;
    if (!en_i || addr_i == '0) begin
      data_o  = '0;
    end else if (ex_we_i && addr_i == ex_dest_i) begin
      // A load or unfinished mul/div in EX has nothing to forward yet
      if (ex_ready_i) data_o = ex_result_i;
      else            stall_o = ENABLE;
    end else if (wb_en_i && addr_i == wb_addr_i) begin
      data_o = wb_data_i;
    end else if (pend_i) begin
      stall_o = ENABLE;
    end else begin
      data_o = arr_data_i;
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with EX/WB bypass and an in-flight
// destination scoreboard that stalls ID on long-latency producers.
module reg_file_sb #(
  parameter int DATA_W     = 32,
  parameter int REG_NUM    = 32,
  parameter int ADDR_W     = 5,
  parameter int READ_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wb_en,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic [READ_PORTS-1:0]        rd_en,
  input  logic [READ_PORTS*ADDR_W-1:0] rd_addr,
  output logic [READ_PORTS*DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0]            ex_dest,
  input  logic                         ex_we,
  input  logic                         ex_ready,
  input  logic [DATA_W-1:0]            ex_result,
  input  logic                         issue_valid,
  input  logic [ADDR_W-1:0]            issue_dest,
  input  logic                         issue_we,
  input  logic                         flush,
  output logic                         stall,
  output logic [REG_NUM-1:0]           pending
);
  import reg_file_sb_pkg::ENABLE;
  import reg_file_sb_pkg::DISABLE;

  logic [DATA_W-1:0]     regs_q [REG_NUM];
  logic [REG_NUM-1:0]    pending_q, pending_d;
  logic [READ_PORTS-1:0] port_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_NUM; r++) regs_q[r] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Clear before set so a new producer on the WB register supersedes the old one
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (wb_en) pending_d[wb_addr] = DISABLE;
      if (issue_valid && issue_we && !stall && issue_dest != '0)
        pending_d[issue_dest] = ENABLE;
    end
    pending_d[0] = DISABLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .en_i        (rd_en[i]),
      .addr_i      (addr),
      .ex_we_i     (ex_we),
      .ex_dest_i   (ex_dest),
      .ex_ready_i  (ex_ready),
      .ex_result_i (ex_result),
      .wb_en_i     (wb_en),
      .wb_addr_i   (wb_addr),
      .wb_data_i   (wb_data),
      .pend_i      (pending_q[addr]),
      .arr_data_i  (regs_q[addr]),
      .data_o      (rd_data[i*DATA_W +: DATA_W]),
      .stall_o     (port_stall[i])
    );
  end

  assign stall   = |port_stall;
  assign pending = pending_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed scenarios then random traffic,
// expectations from an array/bit-vector reference model.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [4:0]  ex_dest;
  logic        ex_we;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        issue_we;
  logic        flush;
  logic        stall;
  logic [31:0] pending;

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .ex_dest(ex_dest),
    .ex_we(ex_we), .ex_ready(ex_ready), .ex_result(ex_result),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_we(issue_we),
    .flush(flush), .stall(stall), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] rd;
    logic        st;
    logic [31:0] pend;
  } exp_t;

  exp_t        expq[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit   [31:0] mregs [32];
  bit          mpend [32];

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin mregs[r] = '0; mpend[r] = 1'b0; end
  endfunction

  function automatic void model_read(input bit en, input bit [4:0] a,
                                     output bit [31:0] d, output bit st);
    d = '0; st = 1'b0;
    if (!en || a == 0) return;
    if (ex_we && a == ex_dest) begin
      if (ex_ready) d = ex_result; else st = 1'b1;
    end else if (wb_en && a == wb_addr) d = wb_data;
    else if (mpend[a]) st = 1'b1;
    else d = mregs[a];
  endfunction

  function automatic exp_t model_expect(input string tag);
    exp_t e;
    bit [31:0] d0, d1;
    bit s0, s1;
    model_read(rd_en[0], rd_addr[4:0], d0, s0);
    model_read(rd_en[1], rd_addr[9:5], d1, s1);
    e.tag = tag;
    e.rd  = {d1, d0};
    e.st  = s0 | s1;
    for (int r = 0; r < 32; r++) e.pend[r] = mpend[r];
    return e;
  endfunction

  function automatic void model_edge(input bit st);
    if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
    if (flush) begin
      for (int r = 0; r < 32; r++) mpend[r] = 1'b0;
    end else begin
      if (wb_en) mpend[wb_addr] = 1'b0;
      if (issue_valid && issue_we && !st && issue_dest != 0) mpend[issue_dest] = 1'b1;
    end
  endfunction

  task automatic idle();
    wb_en = 0; wb_addr = 0; wb_data = 0; rd_en = 0; rd_addr = 0;
    ex_dest = 0; ex_we = 0; ex_ready = 0; ex_result = 0;
    issue_valid = 0; issue_dest = 0; issue_we = 0; flush = 0;
  endtask

  task automatic step(input string tag);
    exp_t e;
    e = model_expect(tag);
    expq.push_back(e);
    @(posedge clk);
    model_edge(e.st);
    #1;
  endtask

  task automatic reset_step(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    expq.push_back(model_expect(tag));
    @(negedge clk);
    #1;
    idle();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        vectors++;
        if (rd_data !== e.rd) begin
          miscompares++;
          $display("FAIL %s rd_data got %h expected %h", e.tag, rd_data, e.rd);
        end
        vectors++;
        if (stall !== e.st) begin
          miscompares++;
          $display("FAIL %s stall got %b expected %b", e.tag, stall, e.st);
        end
        vectors++;
        if (pending !== e.pend) begin
          miscompares++;
          $display("FAIL %s pending got %h expected %h", e.tag, pending, e.pend);
        end
      end
    end
  end

  initial begin : driver
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    reset_step("por");

    // Reset mid-operation
    wb_en = 1; wb_addr = 3; wb_data = 32'h1234; step("wr_r3");
    idle(); rd_en = 2'b01; rd_addr = 10'd3; step("rd_r3");
    reset_step("async_rst");
    rd_en = 2'b11; rd_addr = {5'd3, 5'd3}; step("rd_r3_after_rst");

    // WB bypass then array
    idle(); wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    rd_en = 2'b01; rd_addr = 10'd5; step("wb_bypass");
    wb_en = 0; step("wb_array");

    // Load-use stall
    idle(); ex_dest = 7; ex_we = 1; ex_ready = 0;
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0}; step("load_use");
    ex_ready = 1; ex_result = 32'h55; step("ex_bypass");

    // Scoreboard on a multi-cycle op
    idle(); issue_valid = 1; issue_we = 1; issue_dest = 9; step("issue_r9");
    idle(); rd_en = 2'b01; rd_addr = 10'd9;
    ex_we = 1; ex_dest = 1; ex_ready = 1; ex_result = 32'h11;
    wb_en = 1; wb_addr = 2; wb_data = 32'h22;
    for (int k = 0; k < 3; k++) step("pend_stall");
    ex_we = 0; wb_addr = 9; wb_data = 32'hA5; step("wb_r9");
    wb_en = 0; step("r9_array");

    // Same-edge set and clear
    idle(); issue_valid = 1; issue_we = 1; issue_dest = 4;
    wb_en = 1; wb_addr = 4; wb_data = 32'h44; step("set_clr_r4");
    idle(); rd_en = 2'b10; rd_addr = {5'd4, 5'd0}; step("r4_pending");
    idle(); flush = 1; step("flush_r4");
    idle(); rd_en = 2'b11; rd_addr = {5'd4, 5'd4}; step("r4_value");

    // Flush and zero register
    idle(); issue_valid = 1; issue_we = 1; issue_dest = 2; step("issue_r2");
    issue_dest = 6; step("issue_r6");
    issue_dest = 8; flush = 1; step("flush_issue_r8");
    flush = 0; issue_dest = 0; wb_en = 1; wb_addr = 0; wb_data = 32'hFFFF; step("r0_wr");
    idle(); rd_en = 2'b11; rd_addr = {5'd0, 5'd0}; step("r0_read");

    // Random traffic on a small register window to force hazards
    for (int n = 0; n < 400; n++) begin
      wb_en       = $urandom_range(0, 1);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      rd_en       = 2'($urandom_range(0, 3));
      rd_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_we       = $urandom_range(0, 1);
      ex_dest     = 5'($urandom_range(0, 7));
      ex_ready    = ($urandom_range(0, 3) != 0);
      ex_result   = $urandom;
      issue_valid = $urandom_range(0, 1);
      issue_we    = ($urandom_range(0, 3) != 0);
      issue_dest  = 5'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 15) == 0);
      step("random");
    end

    idle();
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain queue left %0d expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
